// File: rtl/reg_scoreboard_ctrl.sv
// Register scoreboard between decode and execute: tracks in-flight writes and stalls on hazards.
// Optional macro SCOREBOARD_FWD_EN enables per-register result-latency countdowns.
module reg_scoreboard_ctrl #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int LAT_W    = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                issue_wr,
    input  logic [ADDR_W-1:0]   issue_dst,
    input  logic [LAT_W-1:0]    issue_lat,
    input  logic                src1_used,
    input  logic [ADDR_W-1:0]   src1,
    input  logic                src2_used,
    input  logic [ADDR_W-1:0]   src2,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    output logic                stall,
    output logic                issue_fire,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [CNT_W-1:0]    stall_count
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    stall_count_q, stall_count_d;
    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] dst_hit;
    logic [NUM_REGS-1:0] rd_hz;
    logic                raw_hz;
    logic                waw_hz;
    logic                hazard;

    // The register file writes on the same edge as wb, so a written-back register is never a hazard.
    always_comb begin
        wb_hit = '0;
        if (wb_valid) begin
            wb_hit[wb_addr] = 1'b1;
        end
    end

    always_comb begin
        dst_hit = '0;
        if (issue_fire && issue_wr) begin
            dst_hit[issue_dst] = 1'b1;
        end
    end

`ifdef SCOREBOARD_FWD_EN
    logic [LAT_W-1:0] cnt_q [NUM_REGS];
    logic [LAT_W-1:0] cnt_d [NUM_REGS];

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_hz[i] = busy_q[i] & (cnt_q[i] != '0) & ~wb_hit[i];
        end
    end

    // Issue load wins over a same-cycle write-back clear.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (dst_hit[i]) begin
                cnt_d[i] = issue_lat;
            end else if (wb_hit[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    logic unused_issue_lat;
    assign unused_issue_lat = ^issue_lat;

    always_comb begin
        rd_hz = busy_q & ~wb_hit;
    end
`endif

    // WAW always waits for write-back, forwarding or not.
    always_comb begin
        raw_hz = (src1_used & rd_hz[src1]) | (src2_used & rd_hz[src2]);
        waw_hz = issue_wr & busy_q[issue_dst] & ~wb_hit[issue_dst];
        hazard = issue_valid & (raw_hz | waw_hz);
    end

    always_comb begin
        stall      = hazard & ~rst;
        issue_fire = issue_valid & ~hazard & ~rst;
    end

    always_comb begin
        busy_d = (busy_q & ~wb_hit) | dst_hit;
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= '0;
            stall_count_q <= '0;
        end else begin
            busy_q        <= busy_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign busy_vec    = busy_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// Self-checking bench for reg_scoreboard_ctrl; expected {stall, issue_fire} go through a scoreboard queue.
// Works for both the default build and SCOREBOARD_FWD_EN.
module tb_reg_scoreboard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid, issue_wr, src1_used, src2_used, wb_valid;
    logic [2:0]  issue_dst, src1, src2, wb_addr;
    logic [2:0]  issue_lat;
    logic        stall, issue_fire;
    logic [7:0]  busy_vec;
    logic [15:0] stall_count;

    int checks = 0;
    int failures = 0;
    logic [1:0] exp_q[$];
    logic [1:0] e;

    always #5 clk = ~clk;

    reg_scoreboard_ctrl dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_dst(issue_dst), .issue_lat(issue_lat),
        .src1_used(src1_used), .src1(src1), .src2_used(src2_used), .src2(src2),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .stall(stall), .issue_fire(issue_fire), .busy_vec(busy_vec), .stall_count(stall_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_wr = 0; issue_dst = 0; issue_lat = 0;
        src1_used = 0; src1 = 0; src2_used = 0; src2 = 0;
        wb_valid = 0; wb_addr = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic drive(input logic v, input logic wr, input logic [2:0] dst, input logic [2:0] lat,
                         input logic s1u, input logic [2:0] s1, input logic s2u, input logic [2:0] s2,
                         input logic wbv, input logic [2:0] wba);
        issue_valid = v; issue_wr = wr; issue_dst = dst; issue_lat = lat;
        src1_used = s1u; src1 = s1; src2_used = s2u; src2 = s2;
        wb_valid = wbv; wb_addr = wba;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        issue_valid = 1'b1;
        issue_wr = 1'b1;
        #2;
        checks++;
        if ({stall, issue_fire} !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs: got %b exp 00", {stall, issue_fire});
        end
        step();
        idle();
        rst = 1'b0;
        step();
        checks++;
        if (busy_vec !== 8'h00) begin
            failures++;
            $display("FAIL reset_busy: got %h exp 00", busy_vec);
        end
        checks++;
        if (stall_count !== 16'h0000 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_count: got cnt=%h stall=%b exp cnt=0000 stall=0", stall_count, stall);
        end
    endtask

    task automatic test_raw();
        int n_stall;
`ifdef SCOREBOARD_FWD_EN
        n_stall = 0;
`else
        n_stall = 3;
`endif
        do_reset();
        drive(1, 1, 3'd2, 3'd0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(2'b01);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({stall, issue_fire} !== e) begin
            failures++;
            $display("FAIL raw_issue: got %b exp %b", {stall, issue_fire}, e);
        end
        step();
        checks++;
        if (busy_vec !== 8'h04) begin
            failures++;
            $display("FAIL raw_busy: got %h exp 04", busy_vec);
        end
        drive(1, 0, 0, 0, 1, 3'd2, 0, 0, 0, 0);
        for (int i = 0; i < n_stall; i++) begin
            exp_q.push_back(2'b10);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({stall, issue_fire} !== e) begin
                failures++;
                $display("FAIL raw_stall c%0d: got %b exp %b", i, {stall, issue_fire}, e);
            end
            step();
        end
`ifndef SCOREBOARD_FWD_EN
        wb_valid = 1'b1; wb_addr = 3'd2;
`endif
        exp_q.push_back(2'b01);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({stall, issue_fire} !== e) begin
            failures++;
            $display("FAIL raw_release: got %b exp %b", {stall, issue_fire}, e);
        end
        step();
        idle();
        checks++;
        if (stall_count !== 16'(n_stall)) begin
            failures++;
            $display("FAIL raw_count: got %0d exp %0d", stall_count, n_stall);
        end
    endtask

    task automatic test_latency();
        do_reset();
        drive(1, 1, 3'd3, 3'd2, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 1, 3'd3, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(2'b10);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({stall, issue_fire} !== e) begin
                failures++;
                $display("FAIL lat_stall c%0d: got %b exp %b", i, {stall, issue_fire}, e);
            end
            step();
        end
`ifndef SCOREBOARD_FWD_EN
        wb_valid = 1'b1; wb_addr = 3'd3;
`endif
        exp_q.push_back(2'b01);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({stall, issue_fire} !== e) begin
            failures++;
            $display("FAIL lat_fire: got %b exp %b", {stall, issue_fire}, e);
        end
        step();
        idle();
        checks++;
        if (stall_count !== 16'd2) begin
            failures++;
            $display("FAIL lat_count: got %0d exp 2", stall_count);
        end
    endtask

    task automatic test_issue_wb_same_reg();
        do_reset();
        drive(1, 1, 3'd5, 3'd1, 0, 0, 0, 0, 1, 3'd5);
        exp_q.push_back(2'b01);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({stall, issue_fire} !== e) begin
            failures++;
            $display("FAIL iw_first: got %b exp %b", {stall, issue_fire}, e);
        end
        step();
        checks++;
        if (busy_vec !== 8'h20) begin
            failures++;
            $display("FAIL iw_busy1: got %h exp 20", busy_vec);
        end
        exp_q.push_back(2'b01);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({stall, issue_fire} !== e) begin
            failures++;
            $display("FAIL iw_waw_bypass: got %b exp %b", {stall, issue_fire}, e);
        end
        step();
        idle();
        checks++;
        if (busy_vec !== 8'h20) begin
            failures++;
            $display("FAIL iw_busy2: got %h exp 20", busy_vec);
        end
    endtask

    task automatic test_wb_bypass();
        do_reset();
        drive(1, 1, 3'd4, 3'd7, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 3'd4, 1, 3'd4, 0, 0);
        exp_q.push_back(2'b10);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({stall, issue_fire} !== e) begin
            failures++;
            $display("FAIL byp_stall: got %b exp %b", {stall, issue_fire}, e);
        end
        src2_used = 1'b0;
        src1_used = 1'b0;
        exp_q.push_back(2'b01);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({stall, issue_fire} !== e) begin
            failures++;
            $display("FAIL byp_unused_src: got %b exp %b", {stall, issue_fire}, e);
        end
        src2_used = 1'b1;
        wb_valid = 1'b1; wb_addr = 3'd4;
        exp_q.push_back(2'b01);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({stall, issue_fire} !== e) begin
            failures++;
            $display("FAIL byp_fire: got %b exp %b", {stall, issue_fire}, e);
        end
        step();
        idle();
        checks++;
        if (busy_vec !== 8'h00) begin
            failures++;
            $display("FAIL byp_busy: got %h exp 00", busy_vec);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] regs [3] = '{3'd0, 3'd1, 3'd6};
        logic [7:0] exp_busy;
        do_reset();
        exp_busy = 8'h00;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, regs[i], 3'd0, 0, 0, 0, 0, 0, 0);
            exp_busy[regs[i]] = 1'b1;
            step();
            checks++;
            if (busy_vec !== exp_busy) begin
                failures++;
                $display("FAIL b2b_busy c%0d: got %h exp %h", i, busy_vec, exp_busy);
            end
        end
        drive(1, 1, 3'd1, 3'd0, 0, 0, 0, 0, 1, 3'd7);
        exp_q.push_back(2'b10);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({stall, issue_fire} !== e) begin
            failures++;
            $display("FAIL b2b_waw: got %b exp %b", {stall, issue_fire}, e);
        end
        step();
        idle();
        checks++;
        if (busy_vec !== 8'h43) begin
            failures++;
            $display("FAIL b2b_wb_nonbusy: got %h exp 43", busy_vec);
        end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        drive(1, 1, 3'd7, 3'd0, 0, 0, 0, 0, 0, 0);
        step();
        repeat (65539) step();
        checks++;
        if (stall_count !== 16'hFFFF || stall !== 1'b1) begin
            failures++;
            $display("FAIL sat_count: got cnt=%h stall=%b exp cnt=ffff stall=1", stall_count, stall);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy_vec !== 8'h00 || stall_count !== 16'h0000) begin
            failures++;
            $display("FAIL midrst_clear: got busy=%h cnt=%h exp busy=00 cnt=0000", busy_vec, stall_count);
        end
        checks++;
        if ({stall, issue_fire} !== 2'b00) begin
            failures++;
            $display("FAIL midrst_outputs: got %b exp 00", {stall, issue_fire});
        end
        step();
        idle();
        rst = 1'b0;
        wb_valid = 1'b1; wb_addr = 3'd7;
        step();
        idle();
        checks++;
        if (busy_vec !== 8'h00 || stall_count !== 16'h0000) begin
            failures++;
            $display("FAIL post_rst_wb: got busy=%h cnt=%h exp busy=00 cnt=0000", busy_vec, stall_count);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_raw();
        test_latency();
        test_issue_wb_same_reg();
        test_wb_bypass();
        test_back_to_back();
        test_saturate_and_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
